// File: rtl/sr_word_loader.sv
// Parallel-to-serial loader: takes one word over valid/ready and drives d/en/dir of a
// bidirectional shift register for MSB clocks so the word lands there in its original order.
module sr_word_loader #(
  parameter int unsigned MSB = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [MSB-1:0] in_word,
  input  logic           in_dir,
  output logic           d,
  output logic           en,
  output logic           dir,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CW = (MSB > 1) ? $clog2(MSB) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [MSB-1:0]  word_q, word_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic [CW-1:0]   bit_idx;
  logic            accept;
  logic            ready_d, d_d, en_d, dir_d, done_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      word_q   <= '0;
      cnt_q    <= '0;
      in_ready <= 1'b0;
      d        <= 1'b0;
      en       <= 1'b0;
      dir      <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      in_ready <= ready_d;
      d        <= d_d;
      en       <= en_d;
      dir      <= dir_d;
      done     <= done_d;
    end
  end

  // dir holds the captured direction for the whole word; bit k goes out MSB-first for dir=0
  assign cnt_inc = cnt_q + CW'(1);
  assign bit_idx = dir ? cnt_inc : (CW'(MSB - 1) - cnt_inc);
  assign accept  = (state_q == IDLE) && in_valid && in_ready;
  assign busy    = (state_q != IDLE);

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    d_d     = 1'b0;
    en_d    = 1'b0;
    dir_d   = dir;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          word_d  = in_word;
          cnt_d   = '0;
          dir_d   = in_dir;
          en_d    = 1'b1;
          d_d     = in_dir ? in_word[0] : in_word[MSB-1];
          ready_d = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q < CW'(MSB - 1)) begin
          cnt_d = cnt_inc;
          d_d   = word_q[bit_idx];
          en_d  = 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/sr_word_loader.md
# sr_word_loader

Parallel-to-serial front end for `bidirectional_shift_reg`. It accepts one `MSB`-bit word plus a direction over a valid/ready handshake, then drives the shift register's `d`, `en` and `dir` pins for exactly `MSB` clocks. After the last shift the word sits unchanged, in its original bit order, on the shift register's parallel `out`. It then signals completion and waits for the next word.

## Interface
- `MSB`, 8: word width; must match the downstream shift register; legal range ≥ 2.
- `clk`  input  1: system clock; all state updates on rising edge.
- `rstn`  input  1: reset, asynchronous and active-low.
- `in_valid`  input  1: upstream word available.
- `in_ready`  output  1: loader can accept a word (registered).
- `in_word`  input  MSB: word to load; sampled on accept.
- `in_dir`  input  1: direction for this word; sampled on accept.
- `d`  output  1: serial data to the shift register (registered).
- `en`  output  1: shift enable to the shift register (registered).
- `dir`  output  1: direction to the shift register (registered).
- `busy`  output  1: high in SHIFT or DONE.
- `done`  output  1: one-cycle pulse; the word is complete in the shift register.

## Operation
- Downstream direction convention:
  - `dir`=0: shifts toward the MSB; `d` enters bit 0.
  - `dir`=1: shifts toward the LSB; `d` enters bit MSB-1.
- Bit ordering, so the final `out` equals `in_word`:
  - `dir`=0: send `in_word[MSB-1]` first, down to `[0]`.
  - `dir`=1: send `in_word[0]` first, up to `[MSB-1]`.
- State machine has three states: IDLE, SHIFT, DONE.
- Internal registers:
  - word register, `MSB` bits.
  - bit counter `cnt`, `$clog2(MSB)` bits; counts 0..MSB-1 and never wraps past MSB-1.
- Accept occurs when state is IDLE and `in_valid`=1 and `in_ready`=1. On that edge:
  - capture `in_word` and `in_dir`.
  - `cnt` ← 0.
  - `dir` ← `in_dir`; `en` ← 1; `d` ← first bit.
  - `in_ready` ← 0.
  - go to SHIFT.
- IDLE with `in_valid`=0: hold. `en`=0 and `d`=0; `dir` keeps its last value.
- Each edge in SHIFT:
  - If `cnt` < MSB-1: `cnt` ← `cnt`+1 and `d` ← next bit; `en` stays 1.
  - If `cnt` = MSB-1: `en` ← 0, `d` ← 0, `done` ← 1, go to DONE.
- One edge in DONE: `done` ← 0, `in_ready` ← 1, go to IDLE.
- `in_valid`, `in_word` and `in_dir` are ignored outside IDLE.
- `dir` changes only on the accept edge, so it is stable throughout every `en`=1 window.
- `busy` is decoded combinationally from state: (state ≠ IDLE).

## Timing
- Reset asserted, asynchronously:
  - state IDLE, `cnt`=0, word register 0.
  - `in_ready`=0, `d`=0, `en`=0, `dir`=0, `done`=0, `busy`=0.
- First edge after `rstn` rises: `in_ready` ← 1. The first accept is possible on the second edge.
- Accept on edge T0:
  - `en`=1 between T0 and T0+MSB, so the shift register samples on edges T0+1..T0+MSB, exactly MSB shifts.
  - `done`=1 between T0+MSB and T0+MSB+1; the downstream `out` holds the word from T0+MSB onward.
  - `in_ready`=1 after T0+MSB+1; next accept no earlier than edge T0+MSB+2.
  - Throughput: one word per MSB+2 clocks; 10 clocks when MSB=8.
- Reset mid-SHIFT: immediate return to reset values; the partial word is abandoned and no `done` pulse occurs.
- `in_valid` held high continuously: a new word is accepted every MSB+2 clocks; no word is skipped or duplicated.

## Test plan
- Reset: hold `rstn`=0 for 2 clocks.
  - During reset: all outputs 0.
  - One edge after release: `in_ready`=1, `en`=0.
- Word 0xA5 with `in_dir`=0:
  - `d` sequence on en-cycles is 1,0,1,0,0,1,0,1.
  - `en` high exactly 8 clocks; `done` pulses once; shift register `out`=0xA5.
- Word 0x3C with `in_dir`=1:
  - `d` sequence is 0,0,1,1,1,1,0,0 (LSB first).
  - `dir`=1 for the whole en window; `out`=0x3C.
- Back-to-back: `in_valid` held high with words 0x81 then 0x7E.
  - Accepts exactly 10 clocks apart.
  - `out`=0x81 at the first `done` and 0x7E at the second.
- Mid-word change: toggle `in_word`/`in_dir`/`in_valid` after accept.
  - `d`, `dir` and the final `out` are unchanged.
  - `in_ready` stays 0 until the DONE→IDLE edge.
- Reset during SHIFT after 3 shifts:
  - `en`, `d`, `busy` and `done` drop to 0 asynchronously.
  - No `done` pulse.
  - `in_ready`=1 one edge after release; the next word loads correctly.
